// File: rtl/gate_check_sequencer_if.sv
// Handshake and gate-probe bundle between the self-test sequencer and its environment.
interface gate_check_sequencer_if #(
    parameter int CNT_W = 8,
    parameter int IDX_W = 4
);
    logic             start;
    logic             dut_a;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [IDX_W-1:0] first_fail;
    logic             first_fail_vld;

    modport master (
        output start, dut_y,
        input  dut_a, busy, done, pass,
        input  err_count, first_fail, first_fail_vld
    );

    modport slave (
        input  start, dut_y,
        output dut_a, busy, done, pass,
        output err_count, first_fail, first_fail_vld
    );
endinterface

// File: rtl/gate_check_sequencer.sv
// Self-test sequencer for a single-input buffer or inverter gate.
// Define GATE_CHK_INVERT_EN to check an inverter instead of a buffer.
module gate_check_sequencer #(
    parameter int                     NUM_VECTORS   = 16,
    parameter logic [NUM_VECTORS-1:0] PATTERN       = 16'hA5C3,
    parameter int                     SETTLE_CYCLES = 2,
    parameter int                     CNT_W         = 8,
    parameter int                     IDX_W         = $clog2(NUM_VECTORS)
) (
    input logic                  clk,
    input logic                  rst,
    gate_check_sequencer_if.slave bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [SW-1:0]    settle_cnt;
    logic             dut_a;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] err_next;
    logic [IDX_W-1:0] first_fail;
    logic             first_fail_vld;
    logic             expected;
    logic             mismatch;

    always_comb begin
`ifdef GATE_CHK_INVERT_EN
        expected = ~dut_a;
`else
        expected = dut_a;
`endif
        mismatch = bus.dut_y != expected;
        idx_nxt  = idx + 1'b1;
        err_next = err_count;
        // Saturate rather than wrap so a heavily broken gate never reads as clean.
        if (mismatch && (err_count != '1)) begin
            err_next = err_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            dut_a          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state          <= S_DRIVE;
                        idx            <= '0;
                        dut_a          <= PATTERN[0];
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_fail     <= '0;
                        first_fail_vld <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= SW'(SETTLE_CYCLES);
                    state      <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt == SW'(1)) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_vld) begin
                        first_fail     <= idx;
                        first_fail_vld <= 1'b1;
                    end
                    if (idx == LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        idx   <= idx_nxt;
                        dut_a <= PATTERN[idx_nxt];
                        state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dut_a          = dut_a;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.err_count      = err_count;
    assign bus.first_fail     = first_fail;
    assign bus.first_fail_vld = first_fail_vld;
endmodule
